// File: rtl/am2951_bctl.sv
// am2951_bctl: synchronous B-port sequencer for an am2951 bidirectional mailbox.
//
// Turns level-held host read/write requests into am2951 B-side strobes.
// - Write: drive the bus, clock S with CES_/CPS, then wait for FS.
// - Read: enable the B outputs with OEB_, capture R, clear FR with CLRR, then
//   wait for FR to drop.
// FR/FS are synchronised, and data inversion through the port is undone.
//
// Ports
//   clk, rst_            system clock, asynchronous active-low reset
//   wr_req, wr_data      host write request (level) and data
//   wr_ack               one-cycle pulse: write done, FS seen set
//   rd_req               host read request (level)
//   rd_data, rd_valid    captured R contents and one-cycle "new data" pulse
//   err                  one-cycle pulse on a flag-response timeout
//   busy                 sequencer is not idle
//   fr, fs               am2951 R-full / S-full flags (asynchronous)
//   b_in, b_out, b_drive B bus sampled value, driven value, pad output enable
//   ces_, cps            S clock enable (active-low) and S clock
//   oeb_, clrr           B output enable (active-low) and FR clear
//
// All outputs are registered. They reflect the state held during the previous
// cycle, so each strobe appears one clock after the state that requests it.
module am2951_bctl #(
    parameter int unsigned WIDTH  = 8,
    parameter bit          INVERT = 1'b1,
    parameter int unsigned TMO    = 15
) (
    input  logic             clk,
    input  logic             rst_,
    input  logic             wr_req,
    input  logic [WIDTH-1:0] wr_data,
    output logic             wr_ack,
    input  logic             rd_req,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid,
    output logic             err,
    output logic             busy,
    input  logic             fr,
    input  logic             fs,
    input  logic [WIDTH-1:0] b_in,
    output logic [WIDTH-1:0] b_out,
    output logic             b_drive,
    output logic             ces_,
    output logic             cps,
    output logic             oeb_,
    output logic             clrr
);

    typedef enum logic [3:0] {
        StIdle,
        StWSetup,
        StWClk,
        StWHold,
        StWWait,
        StRSetup,
        StRCapt,
        StRAck,
        StRWait
    } state_e;

    // Timeout fires on the wait cycle in which the counter would reach TMO.
    localparam logic [7:0] TmoLast = 8'(TMO - 1);

    state_e     state_q, state_d;
    logic       last_q, last_d;    // 1: last transfer started was a read
    logic [7:0] cnt_q, cnt_d;

    logic fr_meta_q, fr_s_q;
    logic fs_meta_q, fs_s_q;

    logic             wr_elig, rd_elig, tmo_hit;

    logic             ces_d, cps_d, oeb_d, clrr_d, b_drive_d;
    logic [WIDTH-1:0] b_out_d, rd_data_d;
    logic             wr_ack_d, rd_valid_d, err_d, busy_d;

    logic             ces_q, cps_q, oeb_q, clrr_q, b_drive_q;
    logic [WIDTH-1:0] b_out_q, rd_data_q;
    logic             wr_ack_q, rd_valid_q, err_q, busy_q;

    // Flag synchronisers
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            fr_meta_q <= 1'b0;
            fr_s_q    <= 1'b0;
            fs_meta_q <= 1'b0;
            fs_s_q    <= 1'b0;
        end else begin
            fr_meta_q <= fr;
            fr_s_q    <= fr_meta_q;
            fs_meta_q <= fs;
            fs_s_q    <= fs_meta_q;
        end
    end

    assign wr_elig = wr_req && !fs_s_q;
    assign rd_elig = rd_req && fr_s_q;
    assign tmo_hit = (cnt_q == TmoLast);

    // State register
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_q <= StIdle;
            last_q  <= 1'b1;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                // Alternate when both are eligible: a write wins after a read.
                if (wr_elig && (!rd_elig || last_q)) begin
                    state_d = StWSetup;
                    last_d  = 1'b0;
                end else if (rd_elig) begin
                    state_d = StRSetup;
                    last_d  = 1'b1;
                end
            end
            StWSetup: state_d = StWClk;
            StWClk:   state_d = StWHold;
            StWHold: begin
                state_d = StWWait;
                cnt_d   = '0;
            end
            StWWait: begin
                if (fs_s_q || tmo_hit) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StRSetup: state_d = StRCapt;
            StRCapt:  state_d = StRAck;
            StRAck: begin
                state_d = StRWait;
                cnt_d   = '0;
            end
            StRWait: begin
                if (!fr_s_q || tmo_hit) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Output logic
    always_comb begin
        ces_d      = 1'b1;
        cps_d      = 1'b0;
        oeb_d      = 1'b1;
        clrr_d     = 1'b0;
        b_drive_d  = 1'b0;
        b_out_d    = b_out_q;
        rd_data_d  = rd_data_q;
        wr_ack_d   = 1'b0;
        rd_valid_d = 1'b0;
        err_d      = 1'b0;
        busy_d     = (state_q != StIdle);
        unique case (state_q)
            StWSetup: begin
                b_drive_d = 1'b1;
                b_out_d   = INVERT ? ~wr_data : wr_data;
                ces_d     = 1'b0;
            end
            StWClk: begin
                b_drive_d = 1'b1;
                ces_d     = 1'b0;
                cps_d     = 1'b1;
            end
            StWHold: begin
                b_drive_d = 1'b1;
                ces_d     = 1'b0;
            end
            StWWait: begin
                wr_ack_d = fs_s_q;
                err_d    = !fs_s_q && tmo_hit;
            end
            StRSetup: oeb_d = 1'b0;
            StRCapt: begin
                // oeb_ has been low for a full cycle by this edge.
                oeb_d     = 1'b0;
                rd_data_d = INVERT ? ~b_in : b_in;
            end
            StRAck: begin
                clrr_d     = 1'b1;
                rd_valid_d = 1'b1;
            end
            StRWait: err_d = fr_s_q && tmo_hit;
            default: ;
        endcase
    end

    // Output registers; async reset drops every strobe immediately.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            ces_q      <= 1'b1;
            cps_q      <= 1'b0;
            oeb_q      <= 1'b1;
            clrr_q     <= 1'b0;
            b_drive_q  <= 1'b0;
            b_out_q    <= '0;
            rd_data_q  <= '0;
            wr_ack_q   <= 1'b0;
            rd_valid_q <= 1'b0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            ces_q      <= ces_d;
            cps_q      <= cps_d;
            oeb_q      <= oeb_d;
            clrr_q     <= clrr_d;
            b_drive_q  <= b_drive_d;
            b_out_q    <= b_out_d;
            rd_data_q  <= rd_data_d;
            wr_ack_q   <= wr_ack_d;
            rd_valid_q <= rd_valid_d;
            err_q      <= err_d;
            busy_q     <= busy_d;
        end
    end

    assign ces_     = ces_q;
    assign cps      = cps_q;
    assign oeb_     = oeb_q;
    assign clrr     = clrr_q;
    assign b_drive  = b_drive_q;
    assign b_out    = b_out_q;
    assign rd_data  = rd_data_q;
    assign wr_ack   = wr_ack_q;
    assign rd_valid = rd_valid_q;
    assign err      = err_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_am2951_bctl.sv
// Directed bench for am2951_bctl with a small behavioural am2951 B-side model:
// S loads (inverted bus) on a cps rising edge with ces_ low and sets fs;
// a clrr rising edge clears fr; b_in shows ~R while oeb_ is low.
module tb_am2951_bctl;

    logic       clk;
    logic       rst_;
    logic       wr_req;
    logic [7:0] wr_data;
    logic       wr_ack;
    logic       rd_req;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       err;
    logic       busy;
    logic       fr;
    logic       fs;
    logic [7:0] b_in;
    logic [7:0] b_out;
    logic       b_drive;
    logic       ces_;
    logic       cps;
    logic       oeb_;
    logic       clrr;

    int n_checks = 0;
    int n_fail   = 0;

    // am2951 model state
    int         cps_cnt  = 0;
    int         clrr_cnt = 0;
    int         fs_base  = 0;
    int         fr_base  = 0;
    logic       fs_en    = 1'b1;
    logic       fr_arm   = 1'b0;
    logic [7:0] s_a      = 8'h00;
    logic [7:0] r_a      = 8'hAA;

    // Monitor counters
    int wack_cnt = 0;
    int rdv_cnt  = 0;
    int err_cnt  = 0;
    int ovl_cnt  = 0;
    int cc_cnt   = 0;

    am2951_bctl #(
        .WIDTH (8),
        .INVERT(1'b1),
        .TMO   (15)
    ) dut (
        .clk     (clk),
        .rst_    (rst_),
        .wr_req  (wr_req),
        .wr_data (wr_data),
        .wr_ack  (wr_ack),
        .rd_req  (rd_req),
        .rd_data (rd_data),
        .rd_valid(rd_valid),
        .err     (err),
        .busy    (busy),
        .fr      (fr),
        .fs      (fs),
        .b_in    (b_in),
        .b_out   (b_out),
        .b_drive (b_drive),
        .ces_    (ces_),
        .cps     (cps),
        .oeb_    (oeb_),
        .clrr    (clrr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge cps) begin
        cps_cnt = cps_cnt + 1;
        if (!ces_) s_a = ~b_out;
    end

    always @(posedge clrr) clrr_cnt = clrr_cnt + 1;

    assign fs   = fs_en && (cps_cnt != fs_base);
    assign fr   = fr_arm && (clrr_cnt == fr_base);
    assign b_in = oeb_ ? 8'hFF : ~r_a;

    always @(negedge clk) begin
        if (wr_ack) wack_cnt = wack_cnt + 1;
        if (rd_valid) rdv_cnt = rdv_cnt + 1;
        if (err) err_cnt = err_cnt + 1;
        if (b_drive && !oeb_) ovl_cnt = ovl_cnt + 1;
        if (cps && clrr) cc_cnt = cc_cnt + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 'h%0h expected 'h%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // sel: 0 wr_ack, 1 rd_valid, 2 err, 3 wr_ack or rd_valid. k stays -1 on timeout.
    task automatic wait_evt(input int sel, input int max_cyc, output int k);
        k = -1;
        for (int i = 1; i <= max_cyc; i++) begin
            tick();
            if ((sel == 0 && wr_ack) || (sel == 1 && rd_valid) || (sel == 2 && err) ||
                (sel == 3 && (wr_ack || rd_valid))) begin
                k = i;
                break;
            end
        end
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 40; i++) begin
            tick();
            if (!busy) break;
        end
        check_eq(tag, 32'(busy), 0);
    endtask

    task automatic settle_flags();
        fs_base = cps_cnt;
        repeat (3) tick();
    endtask

    initial begin
        int k;
        int w0, r0, e0, c0;

        rst_    = 1'b0;
        wr_req  = 1'b1;
        rd_req  = 1'b1;
        wr_data = 8'h00;

        // Reset with requests held
        repeat (3) tick();
        check_eq("rst_strobes", 32'({ces_, oeb_, cps, clrr, b_drive}), 'b11000);
        check_eq("rst_pulses", 32'({wr_ack, rd_valid, err, busy}), 'b0000);
        check_eq("rst_b_out", 32'(b_out), 'h00);
        check_eq("rst_rd_data", 32'(rd_data), 'h00);
        wr_req = 1'b0;
        rd_req = 1'b0;
        rst_   = 1'b1;
        repeat (5) tick();
        check_eq("idle_no_cps", 32'(cps_cnt), 0);
        check_eq("idle_no_clrr", 32'(clrr_cnt), 0);
        check_eq("idle_strobes", 32'({ces_, oeb_, b_drive, busy}), 'b1100);

        // Write path
        c0      = cps_cnt;
        wr_data = 8'hCC;
        wr_req  = 1'b1;
        k       = -1;
        for (int i = 1; i <= 30; i++) begin
            tick();
            if (i == 2) begin
                check_eq("wr_setup_bout", 32'(b_out), 'h33);
                check_eq("wr_setup_ctl", 32'({ces_, b_drive, cps}), 'b010);
            end
            if (i == 3) check_eq("wr_clk_ctl", 32'({ces_, b_drive, cps}), 'b011);
            if (i == 4) check_eq("wr_hold_ctl", 32'({ces_, b_drive, cps}), 'b010);
            if (i == 5) check_eq("wr_wait_ctl", 32'({ces_, b_drive, cps}), 'b100);
            if (wr_ack) begin
                k = i;
                break;
            end
        end
        wr_req = 1'b0;
        check_eq("wr_ack_latency", k, 6);
        check_eq("wr_one_cps", cps_cnt - c0, 1);
        check_eq("wr_a_side", 32'(s_a), 'hCC);
        tick();
        check_eq("wr_ack_pulse", 32'(wr_ack), 0);
        wait_idle("wr_idle");

        // Read path
        r_a     = 8'hAA;
        fr_base = clrr_cnt;
        fr_arm  = 1'b1;
        repeat (3) tick();
        r0     = rdv_cnt;
        rd_req = 1'b1;
        k      = -1;
        for (int i = 1; i <= 30; i++) begin
            tick();
            if (i == 2) check_eq("rd_setup_oeb", 32'({oeb_, b_drive}), 'b00);
            if (i == 3) begin
                check_eq("rd_capt_data", 32'(rd_data), 'hAA);
                check_eq("rd_capt_oeb", 32'(oeb_), 0);
            end
            if (rd_valid) begin
                k = i;
                break;
            end
        end
        check_eq("rd_valid_latency", k, 4);
        check_eq("rd_clrr_with_valid", 32'({clrr, oeb_}), 'b11);
        repeat (12) tick();
        rd_req = 1'b0;
        check_eq("rd_single", rdv_cnt - r0, 1);
        check_eq("rd_idle", 32'({busy, clrr}), 'b00);

        // Arbitration: write, read, write
        fr_base = clrr_cnt;
        settle_flags();
        wr_data = 8'h5A;
        wr_req  = 1'b1;
        rd_req  = 1'b1;
        wait_evt(3, 30, k);
        check_eq("arb1_is_wr", 32'({wr_ack, rd_valid}), 'b10);
        wr_req = 1'b0;
        rd_req = 1'b0;
        wait_idle("arb1_idle");
        settle_flags();
        wr_req = 1'b1;
        rd_req = 1'b1;
        wait_evt(3, 30, k);
        check_eq("arb2_is_rd", 32'({wr_ack, rd_valid}), 'b01);
        wr_req = 1'b0;
        rd_req = 1'b0;
        wait_idle("arb2_idle");
        fr_base = clrr_cnt;
        settle_flags();
        wr_req = 1'b1;
        rd_req = 1'b1;
        wait_evt(3, 30, k);
        check_eq("arb3_is_wr", 32'({wr_ack, rd_valid}), 'b10);
        wr_req = 1'b0;
        rd_req = 1'b0;
        wait_idle("arb3_idle");
        fr_arm = 1'b0;
        check_eq("no_drive_oeb_overlap", ovl_cnt, 0);
        check_eq("no_cps_clrr_overlap", cc_cnt, 0);

        // Write timeout: fs never sets
        fs_en  = 1'b0;
        repeat (3) tick();
        w0     = wack_cnt;
        e0     = err_cnt;
        wr_req = 1'b1;
        wait_evt(2, 40, k);
        wr_req = 1'b0;
        check_eq("tmo_latency", k, 19);
        tick();
        check_eq("tmo_pulse_busy", 32'({err, busy}), 'b00);
        check_eq("tmo_one_err", err_cnt - e0, 1);
        check_eq("tmo_no_ack", wack_cnt - w0, 0);

        // Reset mid-write
        fs_en   = 1'b1;
        settle_flags();
        c0      = cps_cnt;
        wr_data = 8'h3C;
        wr_req  = 1'b1;
        repeat (2) tick();
        check_eq("mid_pre_ces", 32'({ces_, b_drive}), 'b01);
        #2;
        rst_ = 1'b0;
        #1;
        check_eq("mid_async_strobes", 32'({ces_, b_drive, cps, busy}), 'b1000);
        wr_req = 1'b0;
        #2;
        rst_ = 1'b1;
        repeat (3) tick();
        check_eq("mid_idle", 32'({ces_, busy}), 'b10);
        check_eq("mid_no_cps", cps_cnt - c0, 0);
        wr_req = 1'b1;
        wait_evt(0, 30, k);
        wr_req = 1'b0;
        check_eq("mid_rewrite_latency", k, 6);
        check_eq("mid_rewrite_a_side", 32'(s_a), 'h3C);
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/am2951_bctl.md
# am2951_bctl

Synchronous B-port sequencer for the am2951 bidirectional mailbox. Sits directly on the B side of an am2951 and converts simple host read/write requests into the device's control strobes: CES_/CPS to load the S register, OEB_/CLRR to read and acknowledge the R register. It also synchronizes the FR/FS flags and corrects the device's data inversion. One state machine arbitrates between reads and writes and guards each transfer with a timeout.

## Interface
- `WIDTH`, 8: data width; matches the am2951 instance.
- `INVERT`, 1: when 1, `b_out = ~wr_data` and `rd_data = ~b_in`, so data passes through the inverting port unchanged end to end.
- `TMO`, 15: number of cycles to wait for a flag response before aborting; range 1..255.
- `clk` in 1: single system clock; all state updates on the rising edge.
- `rst_` in 1: reset, asynchronous, active-low.
- `wr_req` in 1: host write request; held level until `wr_ack` or `err`.
- `wr_data` in WIDTH: write data; stable while `wr_req` is high.
- `wr_ack` out 1: one-cycle pulse; the write is complete and FS is seen set.
- `rd_req` in 1: host read request; held level until `rd_valid` or `err`.
- `rd_data` out WIDTH: captured R contents; holds its value until the next capture.
- `rd_valid` out 1: one-cycle pulse; `rd_data` is new.
- `err` out 1: one-cycle pulse on timeout.
- `busy` out 1: high in every state except IDLE.
- `fr` in 1: am2951 R-full flag; asynchronous to `clk`.
- `fs` in 1: am2951 S-full flag; asynchronous to `clk`.
- `b_in` in WIDTH: B bus value as sampled from the pads.
- `b_out` out WIDTH: value driven onto the B bus.
- `b_drive` out 1: pad output enable for `b_out`.
- `ces_` out 1: am2951 S clock enable, active-low.
- `cps` out 1: am2951 S clock.
- `oeb_` out 1: am2951 B output enable, active-low.
- `clrr` out 1: am2951 FR clear, active-high.

## Operation
- `fr` and `fs` each pass through a 2-flop synchronizer, giving `fr_s` and `fs_s`. All decisions use only the synchronized values.
- Reset values: `ces_`=1, `oeb_`=1, `cps`=0, `clrr`=0, `b_drive`=0, `b_out`=0, `rd_data`=0, `wr_ack`=0, `rd_valid`=0, `err`=0, `busy`=0.
- Reset also sets: state=IDLE, synchronizers=0, `last`=read, timeout counter=0.
- All outputs are registered.
- Eligibility: a write is eligible when `wr_req && !fs_s`; a read is eligible when `rd_req && fr_s`.
- Arbitration: if both are eligible, serve the opposite of `last`. `last` updates when a transfer starts.
- States:
  - IDLE: go to WSETUP or RSETUP per arbitration; otherwise stay in IDLE.
  - WSETUP: `b_drive`=1, `b_out` = data, `ces_`=0.
  - WCLK: `cps`=1.
  - WHOLD: `cps`=0; `ces_` and `b_drive` stay asserted.
  - WWAIT: `ces_`=1, `b_drive`=0. Wait for `fs_s`=1, then pulse `wr_ack` and return to IDLE.
  - RSETUP: `oeb_`=0.
  - RCAPT: `oeb_`=0; `rd_data` is loaded from `b_in` (inverted per `INVERT`).
  - RACK: `oeb_`=1, `clrr`=1, pulse `rd_valid`.
  - RWAIT: `clrr`=0. Wait for `fr_s`=0, then return to IDLE. No pulse on exit.
- Timeout: the counter clears on entry to WWAIT or RWAIT and increments in each wait cycle. If it reaches `TMO` first, pulse `err` and return to IDLE with all strobes deasserted.
- RWAIT exists so a stale `fr_s`=1 cannot trigger a second read. WWAIT exists so a stale `fs_s`=0 cannot trigger an overwrite.
- A request dropped mid-transfer does not abort the transfer; the transfer completes and the ack/valid pulse is still generated.
- `cps` and `clrr` are never high together. `b_drive` and `oeb_`=0 are never asserted together.

## Timing
- A write request accepted in IDLE at edge n gives: WSETUP at n+1, `cps` high in cycle n+2, WHOLD n+3, WWAIT from n+4.
- `fs` set by CPS reaches `fs_s` 2 edges later, so the minimum write latency from request acceptance to `wr_ack` is 6 cycles.
- Read: RSETUP at n+1, capture in n+2, `rd_valid` and `clrr` in n+3.
- The drop of `fr_s` after `clrr` takes at least 2 cycles, so the minimum read occupancy is 6 cycles.
- Data setup to CPS is one full cycle (WSETUP); hold is one cycle (WHOLD).
- `b_in` is sampled after one full cycle of `oeb_`=0.
- Asynchronous reset mid-transfer forces all strobes inactive immediately, without waiting for a clock edge. A partially loaded S register or an unacknowledged R is left as-is in the device.

## Test plan
- Reset then idle: hold `rst_`=0 while requests are high → all outputs at their reset values and `busy`=0. After release with `fr`=`fs`=0, no strobe is issued.
- Write path: `wr_data`=8'hCC with a model am2951 (`fs` set on the `cps` edge) → `b_out`=8'h33, one `cps` pulse with `ces_`=0, `wr_ack` exactly 6 cycles after acceptance. The A-side read of S returns 8'hCC.
- Read path: A side loads R=8'hAA so `fr`=1 and `b_in`=8'h55 while `oeb_`=0 → `rd_data`=8'hAA, one `rd_valid` pulse coincident with `clrr`=1, no second read while `rd_req` stays high.
- Arbitration: `fr`=1, `fs`=0, both requests held → order is write, read, write (with `fs` cleared externally in between), with no overlap of `b_drive` and `oeb_`=0.
- Timeout: write with the model never setting `fs` → `err` pulses 1 cycle, `TMO`=15 cycles after WWAIT entry; no `wr_ack`; `busy` drops.
- Reset mid-write: assert `rst_` while `ces_`=0 → `ces_`=1 and `b_drive`=0 without waiting for a clock edge; state returns to IDLE.
